sort_frame_loader: RTL and testbench
====================================

SORT_FRAME_LOADER -- requirements
Module: sort_frame_loader

Interface
REQ-001 M, sort_pkg constant, number of elements per sort frame (sorter input width in elements).
REQ-002 N, sort_pkg constant, element bit width (unsigned).
REQ-003 PAD_VAL, sort_pkg constant ('0), fill value for unused frame slots.
REQ-004 clk  in  1  clock; all logic on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 s_valid  in  1  input sample valid.
REQ-007 s_ready  out  1  loader can accept a sample.
REQ-008 s_data  in  N  input sample, unsigned.
REQ-009 s_last  in  1  marks final sample of a frame.
REQ-010 i_flush  in  1  synchronous discard of partial frame.
REQ-011 i_clr_err  in  1  clears o_ovf.
REQ-012 o_chi  out  [M-1:0][N-1:0]  assembled frame; feeds sort_top i_chi.
REQ-013 o_frame_valid  out  1  one-cycle pulse, o_chi holds a new frame.
REQ-014 o_frame_cnt  out  16  count of emitted frames, wraps 0xFFFF->0.
REQ-015 o_ovf  out  1  sticky: a frame exceeded M samples.

Function
REQ-016 Beat accepted iff s_valid && s_ready; s_ready = 1 except in the cycle i_flush=1 (s_ready=0 then).
REQ-017 FSM states FILL, DROP; reset state FILL.
REQ-018 FILL: accepted beat written to fill-buffer slot cnt (0..M-1); cnt increments by 1.
REQ-019 FILL, accepted beat with s_last=1 or cnt==M-1: frame closes; next cycle o_chi = fill buffer including this beat, slots above it = PAD_VAL; o_frame_valid=1 for exactly that cycle; o_frame_cnt increments.
REQ-020 Latency: closing beat accepted at edge t -> o_chi/o_frame_valid valid after edge t+1; zero bubble, next frame's first beat accepted at edge t+1.
REQ-021 On close, cnt<=0 and fill buffer reset to PAD_VAL in the same edge.
REQ-022 Close at cnt==M-1 with s_last=0: go to DROP, set o_ovf.
REQ-023 DROP: accept and discard all beats; accepted beat with s_last=1 returns to FILL; no frame emitted.
REQ-024 o_chi holds its value between frames; changes only on close.
REQ-025 i_flush=1: cnt<=0, fill buffer<=PAD_VAL, state<=FILL; no frame emitted; flush wins over a simultaneous closing beat (beat not accepted since s_ready=0).
REQ-026 s_last on first beat (cnt==0) emits frame with slot 0 = data, slots 1..M-1 = PAD_VAL.
REQ-027 i_clr_err clears o_ovf; simultaneous set (REQ-022) wins.
REQ-028 Slot order: sample k of frame -> o_chi[k].

Reset
REQ-029 rst_n low: state FILL, cnt 0, fill buffer and o_chi = PAD_VAL, o_frame_valid 0, o_frame_cnt 0, o_ovf 0.
REQ-030 Reset mid-frame discards partial frame; no o_frame_valid after release until a new frame closes.
REQ-031 s_ready 1 in first cycle after rst_n release.

Structure
REQ-032 M, N, PAD_VAL and the FSM state enum live in sort_pkg; module imports sort_pkg.
REQ-033 Single flat module, no sub-modules; instantiated directly upstream of sort_top.

Verification (M=4, N=8)
REQ-034 Beats 0x11,0x22,0x33,0x44(last) back-to-back -> one cycle after 0x44, o_chi={0x44,0x33,0x22,0x11} ([3]..[0]), o_frame_valid pulse, o_frame_cnt=1.
REQ-035 Beats 0x05,0x06(last) -> o_chi={0x00,0x00,0x06,0x05}, single pulse.
REQ-036 Six beats, s_last on sixth -> frame of first four emitted, beats 5-6 dropped, o_ovf=1; i_clr_err then o_ovf=0.
REQ-037 Two 4-beat frames with no idle gap -> two pulses exactly 4 cycles apart, o_frame_cnt=2.
REQ-038 Two beats then i_flush=1 with s_valid=1,s_last=1 -> s_ready=0, no pulse; next 0xAA(last) -> o_chi={0,0,0,0xAA}.
REQ-039 rst_n low after 3 beats -> all outputs reset values; subsequent 4-beat frame emitted correctly with o_frame_cnt=1.

Source files
------------

// File: rtl/sort_pkg.sv
// Shared constants and types for the sort front end.
package sort_pkg;

  localparam int M     = 4;
  localparam int N     = 8;
  localparam int CNT_W = (M > 1) ? $clog2(M) : 1;

  localparam logic [N-1:0] PAD_VAL = '0;

  // A whole frame of padding, used to clear the fill buffer in one assignment.
  localparam logic [M-1:0][N-1:0] PAD_FRAME = {M{PAD_VAL}};

  typedef enum logic {
    FILL = 1'b0,
    DROP = 1'b1
  } state_e;

endpackage

// File: rtl/sort_frame_loader.sv
// Collects up to M streamed samples into one frame for sort_top and emits it
// as a single-cycle pulse. Short frames are padded with PAD_VAL. An over-long
// frame is truncated to M samples, its tail is discarded, and o_ovf is raised.
//
// state | meaning
// FILL  | collecting samples of the current frame into the fill buffer
// DROP  | frame overflowed; discard beats up to and including s_last
module sort_frame_loader
  import sort_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [N-1:0]           s_data,
  input  logic                   s_last,
  input  logic                   i_flush,
  input  logic                   i_clr_err,
  output logic [M-1:0][N-1:0]    o_chi,
  output logic                   o_frame_valid,
  output logic [15:0]            o_frame_cnt,
  output logic                   o_ovf
);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [M-1:0][N-1:0]     buf_q, buf_d;
  logic [M-1:0][N-1:0]     chi_q, chi_d;
  logic                    fv_q, fv_d;
  logic [15:0]             fcnt_q, fcnt_d;
  logic                    ovf_q, ovf_d;
  logic                    beat_acc;
  logic                    slot_full;

  // Flush owns the cycle, so the loader refuses a beat while it is asserted.
  assign s_ready   = ~i_flush;
  assign beat_acc  = s_valid & s_ready;
  assign slot_full = (cnt_q == CNT_W'(M - 1));

  // Next-state and output logic: frame assembly, close, overflow handling.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    chi_d   = chi_q;
    fv_d    = 1'b0;
    fcnt_d  = fcnt_q;
    ovf_d   = ovf_q;

    if (i_clr_err) begin
      ovf_d = 1'b0;
    end

    if (i_flush) begin
      state_d = FILL;
      cnt_d   = '0;
      buf_d   = PAD_FRAME;
    end else if (beat_acc) begin
      case (state_q)
        FILL: begin
          if (s_last || slot_full) begin
            // Emit the buffer plus this beat; slots above it are still padding.
            chi_d        = buf_q;
            chi_d[cnt_q] = s_data;
            fv_d         = 1'b1;
            fcnt_d       = fcnt_q + 16'd1;
            cnt_d        = '0;
            buf_d        = PAD_FRAME;
            if (!s_last) begin
              // Setting the error takes priority over a same-cycle clear.
              state_d = DROP;
              ovf_d   = 1'b1;
            end
          end else begin
            buf_d[cnt_q] = s_data;
            cnt_d        = cnt_q + CNT_W'(1);
          end
        end
        DROP: begin
          if (s_last) begin
            state_d = FILL;
          end
        end
        default: state_d = FILL;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
      cnt_q   <= '0;
      buf_q   <= PAD_FRAME;
      chi_q   <= PAD_FRAME;
      fv_q    <= 1'b0;
      fcnt_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      chi_q   <= chi_d;
      fv_q    <= fv_d;
      fcnt_q  <= fcnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign o_chi         = chi_q;
  assign o_frame_valid = fv_q;
  assign o_frame_cnt   = fcnt_q;
  assign o_ovf         = ovf_q;

endmodule

// File: tb/tb_sort_frame_loader.sv
// Scoreboard bench for sort_frame_loader: the driver models each frame as
// beats are sent and queues the expected frame; the monitor pops and compares
// on every o_frame_valid pulse.
module tb_sort_frame_loader;
  import sort_pkg::*;

  logic                 clk;
  logic                 rst_n;
  logic                 s_valid;
  logic                 s_ready;
  logic [N-1:0]         s_data;
  logic                 s_last;
  logic                 i_flush;
  logic                 i_clr_err;
  logic [M-1:0][N-1:0]  o_chi;
  logic                 o_frame_valid;
  logic [15:0]          o_frame_cnt;
  logic                 o_ovf;

  sort_frame_loader dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .s_data        (s_data),
    .s_last        (s_last),
    .i_flush       (i_flush),
    .i_clr_err     (i_clr_err),
    .o_chi         (o_chi),
    .o_frame_valid (o_frame_valid),
    .o_frame_cnt   (o_frame_cnt),
    .o_ovf         (o_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [M*N-1:0] chi;
    logic [15:0]    cnt;
  } exp_t;

  exp_t exp_q[$];
  int   pulse_cyc[$];
  int   cyc;
  int   n_checks;
  int   n_errors;

  // reference model state
  logic [M-1:0][N-1:0] m_buf;
  int                  m_cnt;
  logic                m_drop;
  logic [15:0]         m_fcnt;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, expv);
    end
  endtask

  always @(posedge clk) cyc++;

  // Monitor: every frame pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && o_frame_valid) begin
      pulse_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("frame_chi", 64'(o_chi), 64'(e.chi));
        chk("frame_cnt", 64'(o_frame_cnt), 64'(e.cnt));
      end
    end
  end

  task automatic model_reset(input logic full);
    m_buf  = {M{PAD_VAL}};
    m_cnt  = 0;
    m_drop = 1'b0;
    if (full) m_fcnt = '0;
  endtask

  task automatic beat(input logic [N-1:0] d, input logic last);
    exp_t e;
    if (!m_drop) begin
      m_buf[m_cnt] = d;
      if (last || m_cnt == M - 1) begin
        m_fcnt = m_fcnt + 16'd1;
        e.chi  = m_buf;
        e.cnt  = m_fcnt;
        exp_q.push_back(e);
        if (!last) m_drop = 1'b1;
        m_buf = {M{PAD_VAL}};
        m_cnt = 0;
      end else begin
        m_cnt++;
      end
    end else if (last) begin
      m_drop = 1'b0;
    end
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    @(posedge clk); #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic drain(input string tag);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    chk(tag, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    logic [M*N-1:0] held;
    int             np;
    n_checks  = 0;
    n_errors  = 0;
    cyc       = 0;
    rst_n     = 1'b0;
    s_valid   = 1'b0;
    s_data    = '0;
    s_last    = 1'b0;
    i_flush   = 1'b0;
    i_clr_err = 1'b0;
    model_reset(1'b1);
    #23;
    chk("rst_chi", 64'(o_chi), 64'd0);
    chk("rst_fv",  64'(o_frame_valid), 64'd0);
    chk("rst_fcnt", 64'(o_frame_cnt), 64'd0);
    chk("rst_ovf", 64'(o_ovf), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_ready", 64'(s_ready), 64'd1);

    // full frame, back to back
    beat(8'h11, 0); beat(8'h22, 0); beat(8'h33, 0); beat(8'h44, 1);
    drain("drain_full");
    chk("fcnt_after_1", 64'(o_frame_cnt), 64'd1);
    held = o_chi;
    idle(3);
    chk("chi_hold", 64'(o_chi), 64'(held));
    chk("chi_full", 64'(o_chi), 64'h44332211);

    // short frame padded
    beat(8'h05, 0); beat(8'h06, 1);
    drain("drain_short");
    idle(2);

    // single-beat frame
    beat(8'h77, 1);
    drain("drain_single");

    // overflow: six beats, last on sixth
    beat(8'hA1, 0); beat(8'hA2, 0); beat(8'hA3, 0); beat(8'hA4, 0);
    beat(8'hA5, 0); beat(8'hA6, 1);
    drain("drain_ovf");
    chk("ovf_set", 64'(o_ovf), 64'd1);
    i_clr_err = 1'b1;
    @(posedge clk); #1;
    i_clr_err = 1'b0;
    chk("ovf_clr", 64'(o_ovf), 64'd0);

    // two frames with no gap -> pulses 4 cycles apart
    np = pulse_cyc.size();
    beat(8'h01, 0); beat(8'h02, 0); beat(8'h03, 0); beat(8'h04, 1);
    beat(8'h05, 0); beat(8'h06, 0); beat(8'h07, 0); beat(8'h08, 1);
    drain("drain_b2b");
    idle(1);
    chk("b2b_pulses", 64'(pulse_cyc.size() - np), 64'd2);
    if (pulse_cyc.size() - np == 2)
      chk("b2b_gap", 64'(pulse_cyc[np+1] - pulse_cyc[np]), 64'd4);

    // flush over a closing beat
    beat(8'h31, 0); beat(8'h32, 0);
    np = pulse_cyc.size();
    s_valid = 1'b1; s_last = 1'b1; s_data = 8'h99; i_flush = 1'b1;
    #1;
    chk("flush_ready", 64'(s_ready), 64'd0);
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0; i_flush = 1'b0;
    model_reset(1'b0);
    idle(2);
    chk("flush_no_pulse", 64'(pulse_cyc.size() - np), 64'd0);
    beat(8'hAA, 1);
    drain("drain_flush");
    idle(1);
    chk("chi_after_flush", 64'(o_chi), 64'h000000AA);

    // reset mid-frame
    beat(8'h51, 0); beat(8'h52, 0); beat(8'h53, 0);
    rst_n = 1'b0;
    #1;
    model_reset(1'b1);
    chk("mid_rst_chi", 64'(o_chi), 64'd0);
    chk("mid_rst_fcnt", 64'(o_frame_cnt), 64'd0);
    chk("mid_rst_ovf", 64'(o_ovf), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    np = pulse_cyc.size();
    idle(2);
    chk("mid_rst_no_pulse", 64'(pulse_cyc.size() - np), 64'd0);
    beat(8'hC1, 0); beat(8'hC2, 0); beat(8'hC3, 0); beat(8'hC4, 1);
    drain("drain_after_rst");
    idle(2);
    chk("fcnt_after_rst", 64'(o_frame_cnt), 64'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
